// File: rtl/async_operator_elastic.sv
// Elastic dataflow operator: one FIFO per input channel, a single result
// register, and a fork to output_size consumers that each acknowledge on
// their own. Fires when every channel has a head entry and the previous
// result has been taken by all consumers.
module async_operator_elastic #(
   parameter int                    data_width  = 32,
   parameter string                 op          = "reg",
   parameter logic [data_width-1:0] immediate   = '0,
   parameter int                    input_size  = 1,
   parameter int                    output_size = 1,
   parameter int                    depth       = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [input_size-1:0]            req_l,
   input  logic [input_size-1:0]            ack_l,
   input  logic [data_width*input_size-1:0] din,
   input  logic [output_size-1:0]           req_r,
   output logic [output_size-1:0]           ack_r,
   output logic [data_width-1:0]            dout
);

   localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
   localparam int cnt_w = $clog2(depth + 1);
   localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
   localparam logic [ptr_w-1:0] last_c  = ptr_w'(depth - 1);

   // Single-operand ops only make sense with one channel; reductions need
   // at least two. Anything else produces zero but still handshakes.
   localparam bit op_unary  = (op == "reg") || (op == "in") || (op == "out") ||
                              (op == "addi") || (op == "subi") || (op == "muli");
   localparam bit op_reduce = (op == "add") || (op == "sub") || (op == "mul") ||
                              (op == "and") || (op == "or") || (op == "xor") ||
                              (op == "min") || (op == "max");
   localparam bit op_defined = (op_unary && input_size == 1) ||
                               (op_reduce && input_size >= 2);

   logic [data_width-1:0]  mem     [input_size][depth];
   logic [ptr_w-1:0]       rd_ptr  [input_size];
   logic [ptr_w-1:0]       wr_ptr  [input_size];
   logic [cnt_w-1:0]       cnt     [input_size];
   logic [cnt_w-1:0]       cnt_nxt [input_size];
   logic [data_width-1:0]  head    [input_size];
   logic [input_size-1:0]  push;
   logic [input_size-1:0]  req_nxt;
   logic                   all_valid;
   logic                   fire;
   logic [output_size-1:0] pending;
   logic [output_size-1:0] ack_nxt;
   logic [data_width-1:0]  result;

   // Join: every channel must hold a head entry.
   always_comb begin
      all_valid = 1'b1;
      for (int g = 0; g < input_size; g++)
         if (cnt[g] == '0) all_valid = 1'b0;
   end

   assign fire    = all_valid && (pending == '0);
   assign ack_nxt = pending & req_r & ~ack_r;

   // Per-channel push/occupancy bookkeeping. req_l reserves a slot, so it
   // only rises when the post-edge occupancy leaves room for one more word.
   always_comb begin
      head    = '{default: '0};
      cnt_nxt = '{default: '0};
      push    = '0;
      req_nxt = '0;
      for (int g = 0; g < input_size; g++) begin
         head[g]    = mem[g][rd_ptr[g]];
         push[g]    = ack_l[g] & req_l[g];
         cnt_nxt[g] = cnt[g] + cnt_w'(push[g]) - cnt_w'(fire);
         req_nxt[g] = ~ack_l[g] && (cnt_nxt[g] < depth_c);
      end
   end

   // Operator datapath on the FIFO heads; ch0 is the first operand.
   always_comb begin
      result = '0;
      if (op_defined) begin
         if (op_unary) begin
            if (op == "addi")      result = head[0] + immediate;
            else if (op == "subi") result = head[0] - immediate;
            else if (op == "muli") result = head[0] * immediate;
            else                   result = head[0];
         end else begin
            result = head[0];
            for (int g = 1; g < input_size; g++) begin
               if (op == "add")      result = result + head[g];
               else if (op == "sub") result = result - head[g];
               else if (op == "mul") result = result * head[g];
               else if (op == "and") result = result & head[g];
               else if (op == "or")  result = result | head[g];
               else if (op == "xor") result = result ^ head[g];
               else if (op == "min") result = (head[g] < result) ? head[g] : result;
               else                  result = (head[g] > result) ? head[g] : result;
            end
         end
      end
   end

   // FIFO storage; writes are gated by req_l, which is low throughout reset.
   always_ff @(posedge clk) begin
      for (int g = 0; g < input_size; g++)
         if (push[g]) mem[g][wr_ptr[g]] <= din[data_width*g +: data_width];
   end

   // FIFO pointers, occupancy and upstream request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_l <= '0;
         for (int g = 0; g < input_size; g++) begin
            rd_ptr[g] <= '0;
            wr_ptr[g] <= '0;
            cnt[g]    <= '0;
         end
      end else begin
         req_l <= req_nxt;
         for (int g = 0; g < input_size; g++) begin
            cnt[g] <= cnt_nxt[g];
            if (push[g]) wr_ptr[g] <= (wr_ptr[g] == last_c) ? '0 : wr_ptr[g] + 1'b1;
            if (fire)    rd_ptr[g] <= (rd_ptr[g] == last_c) ? '0 : rd_ptr[g] + 1'b1;
         end
      end
   end

   // Result register and fork: each output gets exactly one ack pulse per result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout    <= '0;
         pending <= '0;
         ack_r   <= '0;
      end else begin
         ack_r <= ack_nxt;
         if (fire) begin
            dout    <= result;
            pending <= '1;
         end else begin
            pending <= pending & ~ack_nxt;
         end
      end
   end

endmodule

// File: tb/tb_async_operator_elastic.sv
// Bench for async_operator_elastic: three configurations (addi single path,
// 3-way sub join, 3-way reg fork) driven with randomized producers/consumers.
module tb_async_operator_elastic;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [0:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
   logic [31:0] a_din, a_dout;
   logic [2:0]  s_req_l, s_ack_l;
   logic [95:0] s_din;
   logic [0:0]  s_req_r, s_ack_r;
   logic [31:0] s_dout;
   logic [0:0]  f_req_l, f_ack_l;
   logic [31:0] f_din, f_dout;
   logic [2:0]  f_req_r, f_ack_r;

   async_operator_elastic #(.data_width(32), .op("addi"), .immediate(32'd2),
      .input_size(1), .output_size(1), .depth(2)) u_addi (
      .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
      .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout));

   async_operator_elastic #(.data_width(32), .op("sub"), .immediate(32'd0),
      .input_size(3), .output_size(1), .depth(4)) u_sub (
      .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
      .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout));

   async_operator_elastic #(.data_width(32), .op("reg"), .immediate(32'd0),
      .input_size(1), .output_size(3), .depth(2)) u_fork (
      .clk(clk), .rst(rst), .req_l(f_req_l), .ack_l(f_ack_l), .din(f_din),
      .req_r(f_req_r), .ack_r(f_ack_r), .dout(f_dout));

   task automatic idle_inputs();
      a_ack_l = '0; a_req_r = '0; a_din = '0;
      s_ack_l = '0; s_req_r = '0; s_din = '0;
      f_ack_l = '0; f_req_r = '0; f_din = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_ack_l = 1'($urandom); a_req_r = 1'($urandom); a_din = $urandom;
         s_ack_l = 3'($urandom); s_req_r = 1'($urandom); s_din = {$urandom, $urandom, $urandom};
         f_ack_l = 1'($urandom); f_req_r = 3'($urandom); f_din = $urandom;
         #1;
         total++;
         if ({a_req_l, a_ack_r, a_dout} !== 34'd0) begin
            bad++; $display("FAIL reset_addi cyc=%0d got req_l=%b ack_r=%b dout=%h exp all zero", i, a_req_l, a_ack_r, a_dout);
         end
         total++;
         if ({s_req_l, s_ack_r, s_dout} !== 36'd0) begin
            bad++; $display("FAIL reset_sub cyc=%0d got req_l=%b ack_r=%b dout=%h exp all zero", i, s_req_l, s_ack_r, s_dout);
         end
         total++;
         if ({f_req_l, f_ack_r, f_dout} !== 36'd0) begin
            bad++; $display("FAIL reset_fork cyc=%0d got req_l=%b ack_r=%b dout=%h exp all zero", i, f_req_l, f_ack_r, f_dout);
         end
      end
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({a_req_l, s_req_l, f_req_l} !== 5'b11111) begin
         bad++; $display("FAIL reset_release_req got a=%b s=%b f=%b exp all ones", a_req_l, s_req_l, f_req_l);
      end
   endtask

   task automatic test_single_path();
      int n_sent, n_recv, cyc, first_ack, first_out, extra;
      n_sent = 0; n_recv = 0; cyc = 0; first_ack = -1; first_out = -1; extra = 0;
      apply_reset();
      a_req_r = 1'b1;
      while (n_recv < 100 && cyc < 2000) begin
         @(negedge clk); cyc++;
         if (a_ack_r[0] === 1'b1) begin
            total++;
            if (a_dout !== 32'(n_recv + 2)) begin
               bad++; $display("FAIL single_data idx=%0d got=%h exp=%h", n_recv, a_dout, 32'(n_recv + 2));
            end
            if (first_out < 0) first_out = cyc;
            n_recv++;
         end
         if (a_req_l[0] === 1'b1 && n_sent < 100 && (n_sent == 0 || $urandom_range(3) != 0)) begin
            a_ack_l = 1'b1; a_din = 32'(n_sent);
            if (n_sent == 0) first_ack = cyc;
            n_sent++;
         end else begin
            a_ack_l = 1'b0; a_din = $urandom;
         end
      end
      a_ack_l = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (a_ack_r[0] === 1'b1) extra++;
      end
      total++;
      if (n_recv != 100 || extra != 0) begin
         bad++; $display("FAIL single_count got=%0d extra=%0d exp=100 extra=0", n_recv, extra);
      end
      // ack_l cycle ends at edge k; ack_r rises at edge k+2 and is seen on the following negedge.
      total++;
      if (first_out - first_ack != 3) begin
         bad++; $display("FAIL single_latency got=%0d exp=3 (negedges from ack_l drive to ack_r seen)", first_out - first_ack);
      end
   endtask

   task automatic test_join();
      logic [31:0] jv [3][60];
      logic [31:0] exp_v;
      int sent [3];
      int n_recv, cyc;
      for (int c = 0; c < 3; c++) begin
         sent[c] = 0;
         for (int i = 0; i < 60; i++) jv[c][i] = $urandom;
      end
      jv[0][0] = 32'd0; jv[1][0] = 32'd1; jv[2][0] = 32'd1;
      jv[0][1] = 32'd5; jv[1][1] = 32'd2; jv[2][1] = 32'd3;
      n_recv = 0; cyc = 0;
      apply_reset();
      s_req_r = 1'b1;
      while (n_recv < 60 && cyc < 4000) begin
         @(negedge clk); cyc++;
         if (s_ack_r[0] === 1'b1) begin
            exp_v = jv[0][n_recv] - jv[1][n_recv] - jv[2][n_recv];
            total++;
            if (s_dout !== exp_v) begin
               bad++; $display("FAIL join_data idx=%0d got=%h exp=%h", n_recv, s_dout, exp_v);
            end
            if (n_recv == 0) begin
               total++;
               if (s_dout !== 32'hFFFF_FFFE) begin
                  bad++; $display("FAIL join_wrap got=%h exp=fffffffe", s_dout);
               end
            end
            n_recv++;
         end
         for (int c = 0; c < 3; c++) begin
            if (s_req_l[c] === 1'b1 && sent[c] < 60 && (c == 0 || $urandom_range(1) == 1)) begin
               s_ack_l[c] = 1'b1; s_din[32*c +: 32] = jv[c][sent[c]]; sent[c]++;
            end else begin
               s_ack_l[c] = 1'b0; s_din[32*c +: 32] = $urandom;
            end
         end
      end
      s_ack_l = '0;
      total++;
      if (n_recv != 60) begin
         bad++; $display("FAIL join_count got=%0d exp=60", n_recv);
      end
   endtask

   task automatic test_fork();
      logic [31:0] fv [500];
      int nrecv [3];
      int sent, cyc, stall_start;
      for (int i = 0; i < 500; i++) fv[i] = $urandom;
      for (int j = 0; j < 3; j++) nrecv[j] = 0;
      sent = 0; cyc = 0; stall_start = 150;
      apply_reset();
      f_req_r = 3'b111;
      while ((nrecv[0] < 500 || nrecv[1] < 500 || nrecv[2] < 500) && cyc < 5000) begin
         @(negedge clk); cyc++;
         for (int j = 0; j < 3; j++) begin
            if (f_ack_r[j] === 1'b1) begin
               total++;
               if (nrecv[j] >= 500) begin
                  bad++; $display("FAIL fork_extra out=%0d got=%h exp no ack", j, f_dout);
               end else if (f_dout !== fv[nrecv[j]]) begin
                  bad++; $display("FAIL fork_data out=%0d idx=%0d got=%h exp=%h", j, nrecv[j], f_dout, fv[nrecv[j]]);
               end
               nrecv[j]++;
            end
         end
         if (cyc >= stall_start + 4 && cyc < stall_start + 20) begin
            total++;
            if (f_dout !== fv[nrecv[1]] || nrecv[0] > nrecv[1] + 1 || nrecv[2] > nrecv[1] + 1) begin
               bad++; $display("FAIL fork_hold cyc=%0d got dout=%h n0=%0d n2=%0d exp dout=%h n<=%0d",
                               cyc, f_dout, nrecv[0], nrecv[2], fv[nrecv[1]], nrecv[1] + 1);
            end
         end
         f_req_r[1] = !(cyc >= stall_start && cyc < stall_start + 20);
         if (f_req_l[0] === 1'b1 && sent < 500) begin
            f_ack_l = 1'b1; f_din = fv[sent]; sent++;
         end else begin
            f_ack_l = 1'b0; f_din = $urandom;
         end
      end
      f_ack_l = 1'b0;
      for (int j = 0; j < 3; j++) begin
         total++;
         if (nrecv[j] != 500) begin
            bad++; $display("FAIL fork_count out=%0d got=%0d exp=500", j, nrecv[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n_sent, n_recv, cyc, stray;
      n_sent = 0; n_recv = 0; cyc = 0; stray = 0;
      apply_reset();
      a_req_r = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (a_ack_r[0] === 1'b1) stray++;
         if (a_req_l[0] === 1'b1 && n_sent < 20) begin
            a_ack_l = 1'b1; a_din = 32'(n_sent); n_sent++;
         end else begin
            a_ack_l = 1'b0; a_din = $urandom;
         end
      end
      total++;
      if (n_sent != 3) begin
         bad++; $display("FAIL bp_accepted got=%0d exp=3", n_sent);
      end
      total++;
      if (a_req_l !== 1'b0) begin
         bad++; $display("FAIL bp_req_l got=%b exp=0", a_req_l);
      end
      total++;
      if (a_dout !== 32'd2 || stray != 0) begin
         bad++; $display("FAIL bp_held got dout=%h acks=%0d exp dout=00000002 acks=0", a_dout, stray);
      end
      while (n_recv < 20 && cyc < 1000) begin
         @(negedge clk); cyc++;
         if (a_ack_r[0] === 1'b1) begin
            total++;
            if (n_recv >= 20 || a_dout !== 32'(n_recv + 2)) begin
               bad++; $display("FAIL bp_data idx=%0d got=%h exp=%h", n_recv, a_dout, 32'(n_recv + 2));
            end
            n_recv++;
         end
         a_req_r = 1'($urandom_range(1));
         if (a_req_l[0] === 1'b1 && n_sent < 20) begin
            a_ack_l = 1'b1; a_din = 32'(n_sent); n_sent++;
         end else begin
            a_ack_l = 1'b0; a_din = $urandom;
         end
      end
      a_ack_l = 1'b0;
      total++;
      if (n_recv != 20) begin
         bad++; $display("FAIL bp_count got=%0d exp=20", n_recv);
      end
   endtask

   task automatic test_mid_reset();
      int n_sent, n_recv, cyc;
      n_sent = 0; n_recv = 0; cyc = 0;
      apply_reset();
      a_req_r = 1'b1;
      while (n_recv < 37 && cyc < 1000) begin
         @(negedge clk); cyc++;
         if (a_ack_r[0] === 1'b1) begin
            total++;
            if (a_dout !== 32'(n_recv + 2)) begin
               bad++; $display("FAIL mid_pre_data idx=%0d got=%h exp=%h", n_recv, a_dout, 32'(n_recv + 2));
            end
            n_recv++;
         end
         if (a_req_l[0] === 1'b1 && $urandom_range(3) != 0) begin
            a_ack_l = 1'b1; a_din = 32'(n_sent); n_sent++;
         end else begin
            a_ack_l = 1'b0; a_din = $urandom;
         end
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({a_req_l, a_ack_r, a_dout} !== 34'd0 || n_recv != 37) begin
         bad++; $display("FAIL mid_async_clear got req_l=%b ack_r=%b dout=%h n=%0d exp zeros n=37", a_req_l, a_ack_r, a_dout, n_recv);
      end
      repeat (3) begin
         @(negedge clk);
         a_ack_l = 1'($urandom); a_din = $urandom;
      end
      @(negedge clk);
      a_ack_l = 1'b0;
      rst = 1'b1;
      n_sent = 0; n_recv = 0; cyc = 0;
      while (n_recv < 10 && cyc < 500) begin
         @(negedge clk); cyc++;
         if (a_ack_r[0] === 1'b1) begin
            total++;
            if (a_dout !== 32'(n_recv + 2)) begin
               bad++; $display("FAIL mid_restart_data idx=%0d got=%h exp=%h", n_recv, a_dout, 32'(n_recv + 2));
            end
            n_recv++;
         end
         if (a_req_l[0] === 1'b1 && n_sent < 10) begin
            a_ack_l = 1'b1; a_din = 32'(n_sent); n_sent++;
         end else begin
            a_ack_l = 1'b0; a_din = $urandom;
         end
      end
      a_ack_l = 1'b0;
      total++;
      if (n_recv != 10) begin
         bad++; $display("FAIL mid_restart_count got=%0d exp=10", n_recv);
      end
   endtask

   initial begin
      $display("op configs: addi/1 in, sub/3 in, reg/1 in -- all defined for their input_size");
      idle_inputs();
      test_reset();
      test_single_path();
      test_join();
      test_fork();
      test_backpressure();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
